// File: rtl/dest_reg_scoreboard.sv
// rtl/dest_reg_scoreboard.sv - destination register pending-write scoreboard for the 5-stage pipeline
//
// Tracks how many writes are in flight to each architectural register between
// decode/issue and writeback, and tells decode whether its source registers
// (rs, rt) are still waiting on a result.
//
// Ports:
//   clk          pipeline clock, rising edge
//   rst_n        asynchronous active-low reset
//   issue_valid  instruction leaving decode this cycle
//   issue_we     issuing instruction writes a register
//   issue_rd     destination register of the issuing instruction
//   wb_valid     writeback commits a register write this cycle
//   wb_rd        register written at writeback
//   rs, rt       decode-stage source registers
//   rs_busy      rs has a pending write
//   rt_busy      rt has a pending write
//   stall        rs_busy | rt_busy
//   inflight     total pending writes across all registers
//   err          sticky overflow/underflow flag, cleared only by reset
//
// Optional build macro:
//   SCOREBOARD_WB_BYPASS_EN  write-first register file model: a source whose
//                            last pending write retires this cycle reads as
//                            not busy in that same cycle.

module dest_reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int CNT_W    = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    issue_valid,
    input  logic                    issue_we,
    input  logic [ADDR_W-1:0]       issue_rd,
    input  logic                    wb_valid,
    input  logic [ADDR_W-1:0]       wb_rd,
    input  logic [ADDR_W-1:0]       rs,
    input  logic [ADDR_W-1:0]       rt,
    output logic                    rs_busy,
    output logic                    rt_busy,
    output logic                    stall,
    output logic [ADDR_W+CNT_W-1:0] inflight,
    output logic                    err
);

    localparam int               INF_W   = ADDR_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Register 0 is hardwired zero, so it gets no counter at all.
    logic [CNT_W-1:0] cnt_q [1:NUM_REGS-1];
    logic [CNT_W-1:0] cnt_d [1:NUM_REGS-1];
    logic [INF_W-1:0] inflight_q;
    logic [INF_W-1:0] inflight_d;
    logic             err_q;
    logic             err_d;

    logic             issue_ev;
    logic             retire_ev;
    logic             same_reg;
    logic             do_inc;
    logic             do_dec;
    logic             ovf;
    logic             udf;

    logic [CNT_W-1:0] cnt_issue;
    logic [CNT_W-1:0] cnt_wb;
    logic [CNT_W-1:0] cnt_rs;
    logic [CNT_W-1:0] cnt_rt;

    logic             rs_fwd;
    logic             rt_fwd;

    // Counter read ports; address 0 falls through to the default of 0.
    always_comb begin
        cnt_issue = '0;
        cnt_wb    = '0;
        cnt_rs    = '0;
        cnt_rt    = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (issue_rd == ADDR_W'(i)) cnt_issue = cnt_q[i];
            if (wb_rd    == ADDR_W'(i)) cnt_wb    = cnt_q[i];
            if (rs       == ADDR_W'(i)) cnt_rs    = cnt_q[i];
            if (rt       == ADDR_W'(i)) cnt_rt    = cnt_q[i];
        end
    end

    // Event qualification. An issue and a retire hitting the same register
    // cancel out completely: no count change and no error check, even when the
    // counter sits at zero or at saturation.
    always_comb begin
        issue_ev  = issue_valid && issue_we && (issue_rd != '0);
        retire_ev = wb_valid && (wb_rd != '0);
        same_reg  = issue_ev && retire_ev && (issue_rd == wb_rd);

        ovf    = issue_ev  && !same_reg && (cnt_issue == CNT_MAX);
        udf    = retire_ev && !same_reg && (cnt_wb == '0);
        do_inc = issue_ev  && !same_reg && !ovf;
        do_dec = retire_ev && !same_reg && !udf;
    end

    // Next-state for counters, inflight total and sticky error. When both
    // do_inc and do_dec are set they necessarily target different registers.
    always_comb begin
        for (int i = 1; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (do_inc && (issue_rd == ADDR_W'(i))) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
            if (do_dec && (wb_rd == ADDR_W'(i))) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end

        inflight_d = inflight_q;
        case ({do_inc, do_dec})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase

        err_d = err_q || ovf || udf;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++) begin
                cnt_q[i] <= '0;
            end
            inflight_q <= '0;
            err_q      <= 1'b0;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            inflight_q <= inflight_d;
            err_q      <= err_d;
        end
    end

    // Write-first bypass: if the only pending write to a source is retiring
    // right now, the register file already returns the new value, so the
    // source need not stall.
    always_comb begin
`ifdef SCOREBOARD_WB_BYPASS_EN
        rs_fwd = wb_valid && (wb_rd == rs) && (cnt_rs == CNT_W'(1));
        rt_fwd = wb_valid && (wb_rd == rt) && (cnt_rt == CNT_W'(1));
`else
        rs_fwd = 1'b0;
        rt_fwd = 1'b0;
`endif
    end

    always_comb begin
        rs_busy  = (rs != '0) && (cnt_rs != '0) && !rs_fwd;
        rt_busy  = (rt != '0) && (cnt_rt != '0) && !rt_fwd;
        stall    = rs_busy || rt_busy;
        inflight = inflight_q;
        err      = err_q;
    end

endmodule

// File: doc/dest_reg_scoreboard.md
Name: dest_reg_scoreboard

Overview:
- Tracks destination registers of in-flight writes between decode/issue and writeback in the 5-stage MIPS pipeline.
- Consumes the 5-bit destination selected by the decode-stage destination mux, and the 5-bit writeback register at the end of the pipe.
- Answers whether the decode-stage source registers (rs, rt) have a pending write; drives the hazard stall.
- Per-register pending counters allow multiple overlapping writes to the same register.

Parameters:
- NUM_REGS, 32, number of architectural registers; register 0 is hardwired zero.
- ADDR_W, 5, register address width.
- CNT_W, 2, width of each pending counter; maximum in-flight writes per register is 2^CNT_W-1.

Ports:
- clk  input  1  pipeline clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- issue_valid  input  1  instruction leaving decode this cycle.
- issue_we  input  1  issuing instruction writes a register.
- issue_rd  input  ADDR_W  destination register of the issuing instruction (output of the destination mux).
- wb_valid  input  1  writeback stage commits a register write this cycle.
- wb_rd  input  ADDR_W  register written at writeback.
- rs  input  ADDR_W  decode-stage source register 1.
- rt  input  ADDR_W  decode-stage source register 2.
- rs_busy  output  1  rs has a pending write.
- rt_busy  output  1  rt has a pending write.
- stall  output  1  rs_busy OR rt_busy.
- inflight  output  ADDR_W+CNT_W  total pending writes across all registers.
- err  output  1  sticky: overflow or underflow detected.

Behaviour:
- Reset: asynchronous on rst_n low. All counters, inflight and err clear to 0. rs_busy, rt_busy and stall therefore read 0. Reset mid-operation discards all pending entries immediately.
- State: one CNT_W-bit counter per register 1..NUM_REGS-1. Register 0 has no counter and always reads count 0.
- Issue event: issue_valid & issue_we & (issue_rd != 0). Increments cnt[issue_rd] at the clock edge.
- Retire event: wb_valid & (wb_rd != 0). Decrements cnt[wb_rd] at the clock edge.
- Simultaneous issue and retire, same register: count unchanged. Different registers: both updates apply in the same cycle.
- Overflow: an issue when cnt == 2^CNT_W-1 (and no retire to the same register that cycle) saturates the counter and sets err.
- Underflow: a retire when cnt == 0 (and no issue to the same register that cycle) leaves the counter at 0 and sets err.
- err clears only on reset.
- inflight: registered sum of all counters. Updated with the same +1/-1/0 rules, with no change on a saturated overflow or an ignored underflow.
- Busy outputs are combinational from registered counters:
  - rs_busy = (rs != 0) & (cnt[rs] != 0).
  - rt_busy = (rt != 0) & (cnt[rt] != 0).
  - stall = rs_busy | rt_busy.
- An issue in cycle N is visible on busy outputs in cycle N+1. A retire in cycle N clears busy in cycle N+1 (zero-latency counter update, one-cycle visibility).
- No handshake back-pressure. The upstream pipeline must not assert issue_valid while stall is high for that instruction; the block does not gate issue.

Optional Feature:
- Macro: SCOREBOARD_WB_BYPASS_EN.
- Defined: models the write-first register file. If wb_valid and wb_rd equals rs with cnt[rs] == 1, rs_busy is forced 0 in that same cycle; the same rule applies to rt. stall follows the modified busy signals.
- Undefined: busy reflects registered counters only; a retiring register stays busy for the retire cycle.

Test Plan:
- Reset with rs=5, rt=7 -> rs_busy=0, rt_busy=0, stall=0, inflight=0, err=0. Assert rst_n low mid-stream with 3 pending writes -> all outputs 0 immediately, without waiting for a clock edge.
- Issue rd=8, then next cycle rs=8 -> rs_busy=1, stall=1, inflight=1. Retire wb_rd=8 -> cycle after, rs_busy=0, inflight=0. With SCOREBOARD_WB_BYPASS_EN, rs_busy=0 already in the retire cycle.
- Issue rd=0 and retire wb_rd=0 repeatedly with rs=0, rt=0 -> busy never asserts, inflight stays 0, err stays 0.
- Issue rd=3 three times (CNT_W=2) -> cnt=3, err=0. Fourth issue -> err=1, inflight=3. Three retires of 3 -> rt=3 not busy, err still 1.
- Same-cycle issue rd=9 and retire wb_rd=9 with cnt[9]=1 -> cnt stays 1, rs=9 busy. Same-cycle issue rd=4 and retire wb_rd=6 -> cnt[4]+1, cnt[6]-1, inflight unchanged.
- Retire wb_rd=12 with cnt[12]=0 -> err=1, counter stays 0, inflight unchanged.
